// File: rtl/env_vca.sv
// env_vca: envelope-controlled amplifier for the synth voice.
// Each accepted signed sample is multiplied by the latched unsigned envelope
// level with a bit-serial shift-add multiplier, one gain bit per cycle, LSB
// first. The result is rescaled by 2^nbit_data with floor rounding. Full-scale
// gain bypasses the multiplier, so the sample passes through unchanged.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   smp_in           signed input sample
//   smp_valid        single-cycle strobe qualifying smp_in
//   env              unsigned envelope level
//   env_active       voice active; gain forced to 0 when low
//   smp_out          signed scaled sample, held between strobes
//   smp_out_valid    one-cycle pulse when smp_out updates
//   busy             multiplier occupied, new samples are dropped
//   overrun          one-cycle pulse, smp_valid arrived while busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for smp_valid; accepts and latches sample and gain
// MUL   | one shift-add step per cycle, nbit_data cycles
// DONE  | rescale or bypass result, pulse smp_out_valid
module env_vca #(
   parameter int nbit_data = 6,
   parameter int nbit_smp  = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [nbit_smp-1:0] smp_in,
   input  logic                smp_valid,
   input  logic [nbit_data-1:0] env,
   input  logic                env_active,
   output logic [nbit_smp-1:0] smp_out,
   output logic                smp_out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int nbit_acc = nbit_smp + nbit_data;
   localparam int nbit_cnt = $clog2(nbit_data + 1);
   localparam logic [nbit_cnt-1:0] cnt_load = nbit_cnt'(nbit_data - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t                      state, state_nxt;
   logic                        accept;
   logic [nbit_smp-1:0]         smp_reg;
   logic [nbit_data-1:0]        gain;
   logic [nbit_data-1:0]        gain_sh;
   logic [nbit_data-1:0]        gain_in;
   logic signed [nbit_acc-1:0]  acc;
   logic signed [nbit_acc-1:0]  mcand;
   logic [nbit_cnt-1:0]         cnt;

   assign gain_in = env_active ? env : '0;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (smp_valid) begin
               accept    = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // The multiplicand is pre-shifted each step and the working gain copy is
   // shifted down, so bit 0 of gain_sh is always the current gain bit. The
   // original gain is kept for the unity-bypass test in DONE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         smp_reg       <= '0;
         gain          <= '0;
         gain_sh       <= '0;
         acc           <= '0;
         mcand         <= '0;
         cnt           <= '0;
         smp_out       <= '0;
         smp_out_valid <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         smp_out_valid <= 1'b0;
         overrun       <= smp_valid && busy;
         case (state)
            IDLE: begin
               if (accept) begin
                  smp_reg <= smp_in;
                  gain    <= gain_in;
                  gain_sh <= gain_in;
                  mcand   <= {{nbit_data{smp_in[nbit_smp-1]}}, smp_in};
                  acc     <= '0;
                  cnt     <= cnt_load;
               end
            end
            MUL: begin
               if (gain_sh[0]) acc <= acc + mcand;
               mcand   <= mcand <<< 1;
               gain_sh <= gain_sh >> 1;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            DONE: begin
               // Upper slice of acc is acc >>> nbit_data truncated to the
               // sample width; magnitude never grows, so nothing is lost.
               if (gain == '1) smp_out <= smp_reg;
               else            smp_out <= acc[nbit_acc-1:nbit_data];
               smp_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_env_vca.sv
module tb_env_vca;

   logic              clk = 1'b0;
   logic              rstn;
   logic signed [7:0] smp_in;
   logic              smp_valid;
   logic [5:0]        env;
   logic              env_active;
   logic [7:0]        smp_out;
   logic              smp_out_valid;
   logic              busy;
   logic              overrun;

   int n_pass = 0;
   int n_tot  = 0;

   env_vca #(.nbit_data(6), .nbit_smp(8)) dut (
      .clk(clk), .rstn(rstn), .smp_in(smp_in), .smp_valid(smp_valid),
      .env(env), .env_active(env_active), .smp_out(smp_out),
      .smp_out_valid(smp_out_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Result rule: full-scale gain passes the sample through, otherwise
   // floor(s*g/64). Signed int >>> floors toward minus infinity.
   function automatic int model_out(input int s, input int g);
      if (g == 63) return s;
      return (s * g) >>> 6;
   endfunction

   // Transaction-level timing model: an accepted sample at edge c0 keeps the
   // block busy until edge c0+7, where the result appears.
   int cyc, acc_cyc;
   logic m_busy, m_ovr, m_vld;
   int m_out, m_pend;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cyc <= 0; acc_cyc <= -1000; m_busy <= 1'b0; m_ovr <= 1'b0;
         m_vld <= 1'b0; m_out <= 0; m_pend <= 0;
      end else begin
         cyc   <= cyc + 1;
         m_ovr <= smp_valid && m_busy;
         m_vld <= 1'b0;
         if (m_busy && (cyc - acc_cyc == 7)) begin
            m_vld  <= 1'b1;
            m_out  <= m_pend;
            m_busy <= 1'b0;
         end else if (!m_busy && smp_valid) begin
            acc_cyc <= cyc;
            m_pend  <= model_out(int'(smp_in), env_active ? int'(env) : 0);
            m_busy  <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("smp_out_valid", int'(smp_out_valid), int'(m_vld));
      chk("smp_out", int'($signed(smp_out)), m_out);
   end

   // One transaction: strobe, optionally change env at E3, wait for result.
   task automatic run_one(input string name, input int s, input int e,
                          input int act, input int env_late, input int exp);
      int k;
      int nbusy;
      bit seen;
      nbusy = 0;
      seen  = 1'b0;
      @(negedge clk);
      smp_in = 8'(s); env = 6'(e); env_active = act[0]; smp_valid = 1'b1;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         smp_valid = 1'b0;
         if (k == 3 && env_late >= 0) env = 6'(env_late);
         if (busy) nbusy++;
         if (smp_out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
      else begin
         chk({name, "_result"}, int'($signed(smp_out)), exp);
         chk({name, "_latency"}, k - 1, 7);
         chk({name, "_busy_cycles"}, nbusy, 7);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int novr;
      int nres;
      int res[2];
      rstn = 1'b0; smp_valid = 1'b0; smp_in = '0; env = '0; env_active = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out", int'(smp_out), 0);
      chk("rst_valid", int'(smp_out_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      rstn = 1'b1;

      run_one("unity",       -100, 63, 1, -1, -100);
      run_one("scale_pos",    127, 32, 1, -1,   63);
      run_one("scale_neg",   -128, 32, 1, -1,  -64);
      run_one("scale_40",     100, 40, 1, -1,   62);
      run_one("gated",         90, 50, 0, -1,    0);
      run_one("floor_neg",     -1,  1, 1, -1,   -1);
      run_one("floor_pos",      1,  1, 1, -1,    0);
      run_one("gain0_neg",    -77,  0, 1, -1,    0);
      run_one("env_change",   127, 32, 1, 63,   63);

      // smp_valid held high from E0 through E8; sample changes every cycle.
      novr = 0; nres = 0;
      @(negedge clk);
      smp_in = 8'sd20; env = 6'd32; env_active = 1'b1; smp_valid = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k <= 8) smp_in = 8'(-10 * k);
         else        smp_valid = 1'b0;
         if (overrun) novr++;
         if (smp_out_valid && nres < 2) begin
            res[nres] = int'($signed(smp_out));
            nres++;
         end
      end
      chk("ovr_pulses", novr, 7);
      chk("ovr_results", nres, 2);
      if (nres == 2) begin
         chk("ovr_first", res[0], 10);
         chk("ovr_second", res[1], -40);
      end

      // Reset shortly after E3 of an in-flight multiply.
      @(negedge clk);
      smp_in = 8'sd100; env = 6'd63; env_active = 1'b1; smp_valid = 1'b1;
      @(negedge clk);
      smp_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_out", int'(smp_out), 0);
      chk("rstmid_valid", int'(smp_out_valid), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      run_one("after_rst", 127, 32, 1, -1, 63);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/env_vca.md
# env_vca

Envelope-controlled amplifier stage for the simple synth voice. It takes signed oscillator samples and multiplies each one by the unsigned envelope level from the ADSR generator, using a bit-serial shift-add multiplier. The output is the amplitude-shaped sample with a one-cycle valid strobe. It sits between the oscillator and the output DAC/mixer and consumes the envelope's `dout`/`vout` pair.

## Interface
Parameters:
- `nbit_data`, 6: envelope level width. Must match the envelope generator's `nbit_data`.
- `nbit_smp`, 8: audio sample width, two's complement.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `smp_in`, input, `nbit_smp`: signed input sample.
- `smp_valid`, input, 1: `smp_in` is valid this cycle (single-cycle strobe).
- `env`, input, `nbit_data`: unsigned envelope level (envelope `dout`).
- `env_active`, input, 1: voice active (envelope `vout`). When 0, gain is forced to 0.
- `smp_out`, output, `nbit_smp`: signed scaled sample, held between strobes.
- `smp_out_valid`, output, 1: one-cycle pulse when `smp_out` updates.
- `busy`, output, 1: multiplier occupied; new samples are not accepted.
- `overrun`, output, 1: one-cycle pulse when `smp_valid` arrives while busy.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE, `smp_valid`=1:
  - latch `smp_in` into the sample register;
  - latch the gain register as `env` if `env_active`=1, else 0;
  - clear the accumulator and bit counter; go to MUL.
- MUL, one step per cycle for bit i = 0..`nbit_data`-1, LSB first:
  - if gain bit i = 1: acc += sign-extended sample << i.
  - Accumulator width is `nbit_smp`+`nbit_data`, signed, and cannot overflow.
  - After bit `nbit_data`-1, go to DONE.
- DONE:
  - `smp_out` <= acc >>> `nbit_data` (arithmetic shift, floor rounding).
  - Exception: if gain = 2^`nbit_data`-1, `smp_out` <= latched sample exactly (unity bypass).
  - `smp_out_valid` pulses for 1 cycle; go to IDLE.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- `smp_valid` while busy: the sample is dropped, `overrun` pulses in the same cycle, and the in-flight operation is unaffected.
- Changes to `env`/`env_active` after acceptance are ignored until the next acceptance.
- Gain 0 always yields `smp_out` = 0, including for negative samples.
- The result magnitude never exceeds the input magnitude, so no saturation logic is required.

## Timing
- Reset values: state IDLE, `smp_out`=0, `smp_out_valid`=0, `busy`=0, `overrun`=0; accumulator, gain and sample registers = 0.
- Let `smp_valid`=1 be sampled at edge E0.
  - `busy` is high from after E0 until after edge E(`nbit_data`+1), i.e. for `nbit_data`+1 cycles.
  - `smp_out`/`smp_out_valid` update at edge E(`nbit_data`+1): 7 cycles with the default parameters.
- The earliest next acceptance is at edge E(`nbit_data`+2). Throughput is one sample per `nbit_data`+2 cycles.
- The DONE cycle does not accept input. `smp_valid` during DONE counts as an overrun.
- `overrun` and `smp_out_valid` are registered. `overrun` is asserted in the cycle after the offending `smp_valid` edge.
- Reset asserted mid-operation aborts immediately: no `smp_out_valid` is produced and all outputs return to reset values asynchronously.
- `smp_out` holds its last value until the next DONE. It is not cleared when `env_active` drops.

## Test plan
- Unity bypass: `env`=63, `env_active`=1, `smp_in`=-100 strobed at E0 -> `smp_out`=-100 with `smp_out_valid` pulse at E7; `busy` high for 7 cycles.
- Scaling:
  - `env`=32, `smp_in`=127 -> 63.
  - `smp_in`=-128 -> -64.
  - `env`=40, `smp_in`=100 -> 62.
- Gating and floor:
  - `env_active`=0, `env`=50, `smp_in`=90 -> 0.
  - `env`=1, `smp_in`=-1 -> -1.
  - `env`=1, `smp_in`=1 -> 0.
- Overrun: `smp_valid` held high continuously from E0 ->
  - sample at E0 is processed;
  - `overrun` pulses for each of the 7 busy-cycle strobes;
  - the next acceptance occurs at E8;
  - results match the E0 and E8 samples only.
- Envelope change mid-multiply: `env`=32 at E0, `env`=63 at E3, `smp_in`=127 -> `smp_out`=63, not 127.
- Reset mid-MUL: `rstn` low at E3 -> `busy`=0 and `smp_out`=0 immediately; no `smp_out_valid`; after release, the next sample processes normally with 7-cycle latency.
